// File: rtl/crc16_pkg.sv
// Shared constants and FSM state type for the CRC16 transmit framer.
package crc16_pkg;

    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_SEED_DEF = 16'hFFFF;
    localparam int          DATA_W         = 64;
    localparam int          CRC_W          = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2
    } state_t;

endpackage

// File: rtl/crc16_tx_framer_if.sv
// Payload-in / beat-out stream bundle for crc16_tx_framer, with status outputs.
interface crc16_tx_framer_if;
    import crc16_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_sop;
    logic              in_eop;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_crc_beat;
    logic              out_last;
    logic [15:0]       word_count;
    logic              err_sop;
    logic              err_len;

    modport master (
        output in_valid, in_data, in_sop, in_eop, out_ready,
        input  in_ready, out_valid, out_data, out_crc_beat, out_last,
               word_count, err_sop, err_len
    );

    modport slave (
        input  in_valid, in_data, in_sop, in_eop, out_ready,
        output in_ready, out_valid, out_data, out_crc_beat, out_last,
               word_count, err_sop, err_len
    );

endinterface

// File: rtl/crc16_tx_framer_crc16_d64.sv
// CRC16_D64: combinational next-CRC over a 64-bit word, poly x^16+x^15+x^2+1,
// data consumed MSB (bit 63) first, no reflection.
module CRC16_D64
    import crc16_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [CRC_W-1:0]  crc,
    output logic [CRC_W-1:0]  nextcrc
);

    always_comb begin : calc
        logic [CRC_W-1:0] c;
        logic             fb;
        c = crc;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ data[i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC16_POLY : {CRC_W{1'b0}});
        end
        nextcrc = c;
    end

endmodule

// File: rtl/crc16_tx_framer.sv
// Transmit framer: forwards SOP/EOP-delimited 64-bit payload words through a
// one-deep output register and appends a CRC16 trailer beat per packet.
module crc16_tx_framer
    import crc16_pkg::*;
#(
    parameter logic [15:0] CRC_SEED   = CRC16_SEED_DEF,
    parameter bit          INVERT_OUT = 1'b1,
    parameter int unsigned MAX_WORDS  = 128
) (
    input  logic clk,
    input  logic reset_L,
    crc16_tx_framer_if.slave s
);

    localparam logic [15:0] MAX_W16 = MAX_WORDS[15:0];

    state_t            state_reg, state_next;
    logic [CRC_W-1:0]  crc_reg;
    logic [CRC_W-1:0]  crc_base, crc_next;
    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_crc_beat_reg;
    logic              out_last_reg;
    logic [15:0]       word_count_reg;
    logic              err_sop_reg;
    logic              err_len_reg;

    logic out_load, in_ready, xfer;
    logic fwd, start, sop_err, load_trailer;

    assign out_load = !out_valid_reg | s.out_ready;
    assign in_ready = out_load & (state_reg != CRC);
    assign xfer     = s.in_valid & in_ready;

    // A SOP always restarts from the seed, even when it interrupts a packet.
    assign crc_base = (state_reg == IDLE || s.in_sop) ? CRC_SEED : crc_reg;

    CRC16_D64 u_crc (
        .data    (s.in_data),
        .crc     (crc_base),
        .nextcrc (crc_next)
    );

    always_comb begin
        state_next   = state_reg;
        fwd          = 1'b0;
        start        = 1'b0;
        sop_err      = 1'b0;
        load_trailer = 1'b0;
        case (state_reg)
            IDLE: begin
                if (xfer && s.in_sop) begin
                    fwd        = 1'b1;
                    start      = 1'b1;
                    state_next = s.in_eop ? CRC : DATA;
                end
            end
            DATA: begin
                if (xfer) begin
                    fwd        = 1'b1;
                    start      = s.in_sop;
                    sop_err    = s.in_sop;
                    state_next = s.in_eop ? CRC : DATA;
                end
            end
            CRC: begin
                if (out_load) begin
                    load_trailer = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_reg        <= IDLE;
            crc_reg          <= CRC_SEED;
            out_valid_reg    <= 1'b0;
            out_data_reg     <= '0;
            out_crc_beat_reg <= 1'b0;
            out_last_reg     <= 1'b0;
            word_count_reg   <= 16'd0;
            err_sop_reg      <= 1'b0;
            err_len_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            err_sop_reg <= sop_err;
            if (fwd) begin
                crc_reg <= crc_next;
            end
            if (start) begin
                word_count_reg <= 16'd1;
                err_len_reg    <= 1'b0;
            end else if (fwd) begin
                if (word_count_reg != 16'hFFFF) begin
                    word_count_reg <= word_count_reg + 16'd1;
                end
                // The count before this word already reached the limit.
                if (word_count_reg >= MAX_W16) begin
                    err_len_reg <= 1'b1;
                end
            end
            if (out_load) begin
                out_valid_reg    <= fwd | load_trailer;
                out_crc_beat_reg <= load_trailer;
                out_last_reg     <= load_trailer;
                if (fwd) begin
                    out_data_reg <= s.in_data;
                end else if (load_trailer) begin
                    out_data_reg <= {48'd0, (INVERT_OUT ? ~crc_reg : crc_reg)};
                end
            end
        end
    end

    assign s.in_ready     = in_ready;
    assign s.out_valid    = out_valid_reg;
    assign s.out_data     = out_data_reg;
    assign s.out_crc_beat = out_crc_beat_reg;
    assign s.out_last     = out_last_reg;
    assign s.word_count   = word_count_reg;
    assign s.err_sop      = err_sop_reg;
    assign s.err_len      = err_len_reg;

endmodule

// File: tb/tb_crc16_tx_framer.sv
// Bench for crc16_tx_framer: two instances (default, and MAX_WORDS=2 with
// uninverted trailer) share one stimulus; a packet-level model predicts beats.
module tb_crc16_tx_framer;
    import crc16_pkg::*;

    typedef struct packed {
        logic [63:0] data;
        logic        crc_beat;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic        in_ready;
        logic        out_valid;
        logic [63:0] out_data;
        logic        out_crc_beat;
        logic        out_last;
        logic [15:0] word_count;
        logic        err_sop;
        logic        err_len;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset_L = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_sop = 1'b0;
    logic        in_eop = 1'b0;
    logic        out_ready = 1'b1;
    int          ready_mode = 0;
    int          cyc = 0;

    int tests = 0;
    int fails = 0;

    crc16_tx_framer_if ifa ();
    crc16_tx_framer_if ifb ();

    assign ifa.in_valid = in_valid;  assign ifb.in_valid = in_valid;
    assign ifa.in_data  = in_data;   assign ifb.in_data  = in_data;
    assign ifa.in_sop   = in_sop;    assign ifb.in_sop   = in_sop;
    assign ifa.in_eop   = in_eop;    assign ifb.in_eop   = in_eop;
    assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready;

    crc16_tx_framer u_dut_a (
        .clk     (clk),
        .reset_L (reset_L),
        .s       (ifa.slave)
    );

    crc16_tx_framer #(.INVERT_OUT(1'b0), .MAX_WORDS(2)) u_dut_b (
        .clk     (clk),
        .reset_L (reset_L),
        .s       (ifb.slave)
    );

    always #5 clk = ~clk;

    // out_ready pattern 1,0,0 repeating when ready_mode==1.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        #1 out_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference CRC: remainder of (c*x^64 + d*x^16) modulo x^16+x^15+x^2+1.
    function automatic logic [15:0] model_f(input logic [63:0] d, input logic [15:0] c);
        logic [79:0] m;
        m = {c, 64'd0} ^ {d, 16'd0};
        for (int b = 79; b >= 16; b--) begin
            if (m[b]) m[b -: 17] = m[b -: 17] ^ 17'h18005;
        end
        return m[15:0];
    endfunction

    // Per-instance model state (index 0: default, 1: MAX_WORDS=2 uninverted).
    bit          m_inv  [2] = '{1'b1, 1'b0};
    int          m_maxw [2] = '{128, 2};
    bit          m_in_pkt [2];
    logic [15:0] m_crc [2];
    int          m_cnt [2];
    bit          m_errlen [2];
    bit          m_errsop_pend [2];
    bit          stall_prev [2];
    logic [63:0] held [2];
    logic [15:0] last_trailer [2];
    int          trailer_cnt [2];
    int          beat_cnt [2];
    int          errsop_cnt [2];
    beat_t       qa[$];
    beat_t       qb[$];

    function automatic obs_t get_obs(input int k);
        obs_t o;
        if (k == 0) o = '{ifa.in_ready, ifa.out_valid, ifa.out_data, ifa.out_crc_beat,
                           ifa.out_last, ifa.word_count, ifa.err_sop, ifa.err_len};
        else        o = '{ifb.in_ready, ifb.out_valid, ifb.out_data, ifb.out_crc_beat,
                           ifb.out_last, ifb.word_count, ifb.err_sop, ifb.err_len};
        return o;
    endfunction

    function automatic void push_beat(input int k, input beat_t b);
        if (k == 0) qa.push_back(b); else qb.push_back(b);
    endfunction

    function automatic void model_xfer(input int k, input logic [63:0] d, input bit sop, input bit eop);
        if (sop) begin
            if (m_in_pkt[k]) m_errsop_pend[k] = 1'b1;
            m_crc[k]    = model_f(d, 16'hFFFF);
            m_cnt[k]    = 1;
            m_errlen[k] = 1'b0;
            m_in_pkt[k] = 1'b1;
            push_beat(k, '{d, 1'b0, 1'b0});
        end else if (m_in_pkt[k]) begin
            m_crc[k] = model_f(d, m_crc[k]);
            if (m_cnt[k] != 65535) m_cnt[k]++;
            if (m_cnt[k] > m_maxw[k]) m_errlen[k] = 1'b1;
            push_beat(k, '{d, 1'b0, 1'b0});
        end
        if (m_in_pkt[k] && eop) begin
            push_beat(k, '{{48'd0, (m_inv[k] ? ~m_crc[k] : m_crc[k])}, 1'b1, 1'b1});
            m_in_pkt[k] = 1'b0;
        end
    endfunction

    // Compare process: inputs and outputs are stable at the falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            obs_t  o;
            beat_t e;
            o = get_obs(k);
            if (!reset_L) begin
                if (k == 0) qa.delete(); else qb.delete();
                m_in_pkt[k] = 1'b0; m_cnt[k] = 0; m_errlen[k] = 1'b0;
                m_errsop_pend[k] = 1'b0; stall_prev[k] = 1'b0;
                check("reset_out_valid", {63'd0, o.out_valid}, 64'd0);
                continue;
            end
            check("word_count", {48'd0, o.word_count}, 64'(m_cnt[k]));
            check("err_len", {63'd0, o.err_len}, {63'd0, m_errlen[k]});
            check("err_sop", {63'd0, o.err_sop}, {63'd0, m_errsop_pend[k]});
            if (o.err_sop) errsop_cnt[k]++;
            m_errsop_pend[k] = 1'b0;
            if (o.out_valid) begin
                if (stall_prev[k]) check("stall_hold", o.out_data, held[k]);
                if ((k == 0 ? qa.size() : qb.size()) == 0) begin
                    check("unexpected_beat", {63'd0, o.out_valid}, 64'd0);
                end else begin
                    e = (k == 0) ? qa[0] : qb[0];
                    check("out_data", o.out_data, e.data);
                    check("out_crc_beat", {63'd0, o.out_crc_beat}, {63'd0, e.crc_beat});
                    check("out_last", {63'd0, o.out_last}, {63'd0, e.last});
                    if (out_ready) begin
                        if (k == 0) void'(qa.pop_front()); else void'(qb.pop_front());
                        beat_cnt[k]++;
                        $display("[TB] dut%0d beat data=%016h crc_beat=%0b last=%0b wc=%0d",
                                 k, o.out_data, o.out_crc_beat, o.out_last, o.word_count);
                        if (o.out_crc_beat) begin
                            last_trailer[k] = o.out_data[15:0];
                            trailer_cnt[k]++;
                        end
                    end
                end
            end
            stall_prev[k] = o.out_valid && !out_ready;
            held[k]       = o.out_data;
            if (in_valid && o.in_ready) model_xfer(k, in_data, in_sop, in_eop);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one word and hold it until accepted (bounded).
    task automatic send_word(input logic [63:0] d, input bit sop, input bit eop);
        int budget;
        budget = 50;
        in_valid = 1'b1; in_data = d; in_sop = sop; in_eop = eop;
        forever begin
            @(negedge clk);
            if (ifa.in_ready) break;
            if (--budget == 0) begin
                check("in_ready_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 100;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() == 0 && qb.size() == 0 && !ifa.out_valid && !ifb.out_valid) break;
            if (--budget == 0) begin
                check("drain_timeout", 64'd0, 64'd1);
                break;
            end
        end
        tick(1);
    endtask

    task automatic expect_trailer(input string name, input int ta0, input int tb0,
                                  input logic [15:0] exp_a, input logic [15:0] exp_b);
        check({name, "_trailers_a"}, 64'(trailer_cnt[0]), 64'(ta0 + 1));
        check({name, "_trailers_b"}, 64'(trailer_cnt[1]), 64'(tb0 + 1));
        check({name, "_crc_a"}, {48'd0, last_trailer[0]}, {48'd0, exp_a});
        check({name, "_crc_b"}, {48'd0, last_trailer[1]}, {48'd0, exp_b});
    endtask

    initial begin
        int ta, tbn, nb, es;
        #2;
        check("rst_out_valid", {63'd0, ifa.out_valid}, 64'd0);
        check("rst_out_data", ifa.out_data, 64'd0);
        check("rst_crc_beat", {62'd0, ifa.out_crc_beat, ifa.out_last}, 64'd0);
        check("rst_word_count", {48'd0, ifa.word_count}, 64'd0);
        check("rst_errs", {62'd0, ifa.err_sop, ifa.err_len}, 64'd0);
        check("model_1w", {48'd0, model_f(64'd0, 16'hFFFF)}, 64'h02D0);
        check("model_2w", {48'd0, model_f(64'd0, model_f(64'd0, 16'hFFFF))}, 64'h7D0F);
        tick(3);
        reset_L = 1'b1;
        tick(2);

        // One-word zero packet.
        ta = trailer_cnt[0]; tbn = trailer_cnt[1];
        send_word(64'd0, 1'b1, 1'b1);
        drain();
        expect_trailer("one_word", ta, tbn, 16'hFD2F, 16'h02D0);
        check("one_word_count", {48'd0, ifa.word_count}, 64'd1);

        // Two zero words; exactly one input bubble after EOP.
        ta = trailer_cnt[0]; tbn = trailer_cnt[1];
        send_word(64'd0, 1'b1, 1'b0);
        send_word(64'd0, 1'b0, 1'b1);
        check("bubble_low", {63'd0, ifa.in_ready}, 64'd0);
        tick(1);
        check("bubble_end", {63'd0, ifa.in_ready}, 64'd1);
        drain();
        expect_trailer("two_word", ta, tbn, 16'h82F0, 16'h7D0F);
        check("two_word_count", {48'd0, ifa.word_count}, 64'd2);

        // Same packet under downstream backpressure.
        ready_mode = 1;
        tick(1);
        ta = trailer_cnt[0]; tbn = trailer_cnt[1];
        send_word(64'd0, 1'b1, 1'b0);
        send_word(64'd0, 1'b0, 1'b1);
        drain();
        expect_trailer("stall", ta, tbn, 16'h82F0, 16'h7D0F);
        ready_mode = 0;
        tick(2);

        // SOP arriving mid-packet restarts the packet.
        ta = trailer_cnt[0]; tbn = trailer_cnt[1]; es = errsop_cnt[0];
        send_word(64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
        send_word(64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0);
        send_word(64'd0, 1'b1, 1'b1);
        check("err_sop_pulse", {63'd0, ifa.err_sop}, 64'd1);
        tick(1);
        check("err_sop_clear", {63'd0, ifa.err_sop}, 64'd0);
        drain();
        expect_trailer("resop", ta, tbn, 16'hFD2F, 16'h02D0);
        check("resop_count", {48'd0, ifa.word_count}, 64'd1);
        check("resop_pulses", 64'(errsop_cnt[0]), 64'(es + 1));

        // Three words: over the limit for instance b only.
        send_word(64'h1111_2222_3333_4444, 1'b1, 1'b0);
        send_word(64'd0, 1'b0, 1'b0);
        check("len_before", {63'd0, ifb.err_len}, 64'd0);
        send_word(64'hFFFF_0000_FFFF_0000, 1'b0, 1'b1);
        check("len_rise", {63'd0, ifb.err_len}, 64'd1);
        drain();
        check("len_sticky_b", {63'd0, ifb.err_len}, 64'd1);
        check("len_clear_a", {63'd0, ifa.err_len}, 64'd0);
        send_word(64'd0, 1'b1, 1'b1);
        check("len_cleared", {63'd0, ifb.err_len}, 64'd0);
        drain();

        // Words without SOP in IDLE are dropped.
        nb = beat_cnt[0];
        send_word(64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b0);
        send_word(64'h5555_5555_5555_5555, 1'b0, 1'b1);
        tick(3);
        check("idle_drop_valid", {63'd0, ifa.out_valid}, 64'd0);
        check("idle_drop_beats", 64'(beat_cnt[0]), 64'(nb));

        // Reset mid-packet discards the partial packet.
        send_word(64'h0BAD_0BAD_0BAD_0BAD, 1'b1, 1'b0);
        send_word(64'h0000_1111_2222_3333, 1'b0, 1'b0);
        reset_L = 1'b0;
        #1;
        check("mid_reset_valid", {63'd0, ifa.out_valid}, 64'd0);
        check("mid_reset_count", {48'd0, ifa.word_count}, 64'd0);
        tick(2);
        reset_L = 1'b1;
        tick(1);
        ta = trailer_cnt[0]; tbn = trailer_cnt[1];
        send_word(64'd0, 1'b1, 1'b1);
        drain();
        expect_trailer("post_reset", ta, tbn, 16'hFD2F, 16'h02D0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
